// File: rtl/sparce_sasa_table_pkg.sv
// rtl/sparce_sasa_table_pkg.sv - shared types and offsets for the SparCE SASA table
// Purpose: entry layout, skip-condition encoding, store offsets and stager states.
// Ports: none (package).
package sparce_sasa_table_pkg;

  typedef enum logic [1:0] {
    COND_RS1_ZERO    = 2'b00,
    COND_RS2_ZERO    = 2'b01,
    COND_EITHER_ZERO = 2'b10,
    COND_BOTH_ZERO   = 2'b11
  } sasa_cond_t;

  typedef struct packed {
    logic [29:0] tag;
    logic [15:0] insts;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    sasa_cond_t  cond;
    logic        valid;
  } sasa_entry_t;

  localparam logic [31:0] SASA_TAG_OFF  = 32'h0;
  localparam logic [31:0] SASA_DATA_OFF = 32'h4;
  localparam logic [31:0] SASA_CFG_OFF  = 32'h8;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_HAVE_TAG = 1'b1
  } sasa_stage_t;

endpackage

// File: rtl/sparce_sasa_table_if.sv
// rtl/sparce_sasa_table_if.sv - lookup/store bus of the SASA table
// Purpose: groups the fetch pc, execute-stage store port and registered lookup results.
// Ports: slave modport = table side, master modport = pipeline side.
interface sparce_sasa_table_if;
  logic [31:0] pc;
  logic        sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic        sasa_hit;
  logic [15:0] sasa_insts;
  logic [4:0]  sasa_rs1;
  logic [4:0]  sasa_rs2;
  logic [1:0]  sasa_cond;
  logic        sasa_enable;

  modport slave (
    input  pc, sasa_wen, sasa_addr, sasa_data,
    output sasa_hit, sasa_insts, sasa_rs1, sasa_rs2, sasa_cond, sasa_enable
  );

  modport master (
    output pc, sasa_wen, sasa_addr, sasa_data,
    input  sasa_hit, sasa_insts, sasa_rs1, sasa_rs2, sasa_cond, sasa_enable
  );
endinterface

// File: rtl/sparce_sasa_table_cam.sv
// rtl/sparce_sasa_table_cam.sv - parallel tag compare across all SASA entries
// Purpose: one-hot match of i_key against valid tags plus encoded index.
// Ports: i_tags/i_valid entry tags and valid bits, i_key search tag,
//        o_match one-hot, o_hit any match, o_idx encoded match index.
module sparce_sasa_table_cam #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0][29:0] i_tags,
  input  logic [N-1:0]       i_valid,
  input  logic [29:0]        i_key,
  output logic [N-1:0]       o_match,
  output logic               o_hit,
  output logic [IW-1:0]      o_idx
);

  // Tags are unique by construction, so an OR-encoder is enough; no priority needed.
  always_comb begin
    o_match = '0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      o_match[i] = i_valid[i] && (i_tags[i] == i_key);
      if (o_match[i]) o_idx = o_idx | IW'(i);
    end
    o_hit = |o_match;
  end

endmodule

// File: rtl/sparce_sasa_table.sv
// rtl/sparce_sasa_table.sv - SparCE skip-address/skip-amount table
// Purpose: software-programmed, fully associative table looked up by fetch pc.
// Ports: CLK, nRST (async active-low), bus (slave modport: pc, sasa_wen/addr/data in;
//        sasa_hit/insts/rs1/rs2/cond/enable out, registered).
module sparce_sasa_table
  import sparce_sasa_table_pkg::*;
#(
  parameter int          SASA_ENTRIES = 16,
  parameter logic [31:0] SASA_ADDR    = 32'h0000_1000
) (
  input logic                 CLK,
  input logic                 nRST,
  sparce_sasa_table_if.slave  bus
);

  localparam int IW = $clog2(SASA_ENTRIES);

  sasa_entry_t r_entries [SASA_ENTRIES];
  logic [IW-1:0] r_ptr;
  logic [29:0]   r_tag_q;
  logic          r_enable;
  sasa_stage_t   r_stage;
  sasa_stage_t   w_stage_next;
  logic          r_hit;
  logic [15:0]   r_insts;
  logic [4:0]    r_rs1;
  logic [4:0]    r_rs2;
  sasa_cond_t    r_cond;

  logic [SASA_ENTRIES-1:0][29:0] w_tags;
  logic [SASA_ENTRIES-1:0]       w_valid;
  logic [SASA_ENTRIES-1:0]       w_lk_match;
  logic [SASA_ENTRIES-1:0]       w_wr_match;
  logic                          w_lk_hit;
  logic                          w_wr_hit;
  logic [IW-1:0]                 w_lk_idx;
  logic [IW-1:0]                 w_wr_idx;
  logic                          w_tag_sel;
  logic                          w_data_sel;
  logic                          w_cfg_sel;
  logic                          w_data_act;
  logic                          w_clear;
  sasa_entry_t                   w_new;
  logic                          w_unused;

  assign w_tag_sel  = bus.sasa_wen && (bus.sasa_addr == SASA_ADDR + SASA_TAG_OFF);
  assign w_data_sel = bus.sasa_wen && (bus.sasa_addr == SASA_ADDR + SASA_DATA_OFF);
  assign w_cfg_sel  = bus.sasa_wen && (bus.sasa_addr == SASA_ADDR + SASA_CFG_OFF);
  assign w_data_act = w_data_sel && (r_stage == ST_HAVE_TAG);
  assign w_clear    = w_cfg_sel && bus.sasa_data[1];
  assign w_unused   = &{1'b0, bus.sasa_data[3:1], bus.pc[1:0], w_lk_match, w_wr_match};

  assign w_new = '{tag:   r_tag_q,
                   insts: bus.sasa_data[31:16],
                   rs1:   bus.sasa_data[15:11],
                   rs2:   bus.sasa_data[10:6],
                   cond:  sasa_cond_t'(bus.sasa_data[5:4]),
                   valid: 1'b1};

  always_comb begin
    w_tags  = '0;
    w_valid = '0;
    for (int i = 0; i < SASA_ENTRIES; i++) begin
      w_tags[i]  = r_entries[i].tag;
      w_valid[i] = r_entries[i].valid;
    end
  end

  sparce_sasa_table_cam #(.N(SASA_ENTRIES), .IW(IW)) u_lookup_cam (
    .i_tags  (w_tags),
    .i_valid (w_valid),
    .i_key   (bus.pc[31:2]),
    .o_match (w_lk_match),
    .o_hit   (w_lk_hit),
    .o_idx   (w_lk_idx)
  );

  // Write-side match finds an existing entry for the staged tag (in-place update/invalidate).
  sparce_sasa_table_cam #(.N(SASA_ENTRIES), .IW(IW)) u_write_cam (
    .i_tags  (w_tags),
    .i_valid (w_valid),
    .i_key   (r_tag_q),
    .o_match (w_wr_match),
    .o_hit   (w_wr_hit),
    .o_idx   (w_wr_idx)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_stage <= ST_IDLE;
    else       r_stage <= w_stage_next;
  end

  always_comb begin
    w_stage_next = r_stage;
    if (w_clear)         w_stage_next = ST_IDLE;
    else if (w_tag_sel)  w_stage_next = ST_HAVE_TAG;
    else if (w_data_sel) w_stage_next = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SASA_ENTRIES; i++) r_entries[i] <= '0;
      r_ptr    <= '0;
      r_tag_q  <= '0;
      r_enable <= 1'b0;
    end else begin
      if (w_tag_sel) r_tag_q <= bus.sasa_data[31:2];
      if (w_cfg_sel) begin
        r_enable <= bus.sasa_data[0];
        if (bus.sasa_data[1]) begin
          for (int i = 0; i < SASA_ENTRIES; i++) r_entries[i].valid <= 1'b0;
          r_ptr <= '0;
        end
      end
      if (w_data_act) begin
        if (bus.sasa_data[0]) begin
          if (w_wr_hit) begin
            r_entries[w_wr_idx] <= w_new;
          end else begin
            r_entries[r_ptr] <= w_new;
            r_ptr            <= r_ptr + IW'(1);
          end
        end else if (w_wr_hit) begin
          r_entries[w_wr_idx].valid <= 1'b0;
        end
      end
    end
  end

  // Lookup uses pre-edge table contents and enable, so results lag pc by one cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit   <= 1'b0;
      r_insts <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_cond  <= COND_RS1_ZERO;
    end else if (w_lk_hit && r_enable) begin
      r_hit   <= 1'b1;
      r_insts <= r_entries[w_lk_idx].insts;
      r_rs1   <= r_entries[w_lk_idx].rs1;
      r_rs2   <= r_entries[w_lk_idx].rs2;
      r_cond  <= r_entries[w_lk_idx].cond;
    end else begin
      r_hit   <= 1'b0;
      r_insts <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_cond  <= COND_RS1_ZERO;
    end
  end

  assign bus.sasa_hit    = r_hit;
  assign bus.sasa_insts  = r_insts;
  assign bus.sasa_rs1    = r_rs1;
  assign bus.sasa_rs2    = r_rs2;
  assign bus.sasa_cond   = r_cond;
  assign bus.sasa_enable = r_enable;

endmodule

// File: tb/tb_sparce_sasa_table.sv
// tb/tb_sparce_sasa_table.sv - self-checking bench for sparce_sasa_table
module tb_sparce_sasa_table;

  localparam logic [31:0] A_TAG  = 32'h0000_1000;
  localparam logic [31:0] A_DATA = 32'h0000_1004;
  localparam logic [31:0] A_CFG  = 32'h0000_1008;

  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_err;
  logic [28:0] got;
  logic [28:0] exp;
  logic [28:0] exp_q[$];

  sparce_sasa_table_if u_if ();

  sparce_sasa_table u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (u_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [28:0] hv(input logic [15:0] n, input logic [4:0] a,
                                     input logic [4:0] b, input logic [1:0] c);
    return {1'b1, n, a, b, c};
  endfunction

  function automatic logic [31:0] dw(input logic [15:0] n, input logic [4:0] a,
                                     input logic [4:0] b, input logic [1:0] c, input logic v);
    return {n, a, b, c, 3'b000, v};
  endfunction

  function automatic logic [28:0] obs();
    return {u_if.sasa_hit, u_if.sasa_insts, u_if.sasa_rs1, u_if.sasa_rs2, u_if.sasa_cond};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    u_if.sasa_wen  = 1'b1;
    u_if.sasa_addr = a;
    u_if.sasa_data = d;
    cyc();
    u_if.sasa_wen  = 1'b0;
    u_if.sasa_addr = 32'h0;
    u_if.sasa_data = 32'h0;
  endtask

  task automatic add(input logic [31:0] tag, input logic [31:0] d);
    store(A_TAG, tag);
    store(A_DATA, d);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    u_if.pc = 32'h200;
    u_if.sasa_wen = 1'b0;
    u_if.sasa_addr = 32'h0;
    u_if.sasa_data = 32'h0;
    repeat (3) cyc();
    n_cmp++;
    if ({obs(), u_if.sasa_enable} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", {obs(), u_if.sasa_enable});
    end
    nRST = 1'b1;
    exp_q.push_back(29'd0);
    cyc();
    got = obs();
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_lookup got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_basic();
    logic [31:0] pcs [3];
    logic [28:0] exps [3];
    pcs[0] = 32'h200; exps[0] = hv(3, 1, 2, 0);
    pcs[1] = 32'h202; exps[1] = hv(3, 1, 2, 0);
    pcs[2] = 32'h204; exps[2] = 29'd0;
    store(A_CFG, 32'h1);
    n_cmp++;
    if (u_if.sasa_enable !== 1'b1) begin
      n_err++;
      $display("FAIL enable_set got=%b exp=1", u_if.sasa_enable);
    end
    add(32'h200, 32'h0003_0881);
    for (int i = 0; i < 3; i++) begin
      u_if.pc = pcs[i];
      exp_q.push_back(exps[i]);
      cyc();
      got = obs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL basic_lookup pc=%h got=%h exp=%h", pcs[i], got, exp);
      end
    end
  endtask

  task automatic test_stager();
    logic [31:0] pcs [3];
    logic [28:0] exps [3];
    pcs[0] = 32'h200; exps[0] = hv(3, 1, 2, 0);
    pcs[1] = 32'h400; exps[1] = hv(7, 3, 4, 1);
    pcs[2] = 32'h300; exps[2] = 29'd0;
    store(A_DATA, dw(5, 0, 0, 0, 1));
    store(A_TAG, 32'h300);
    store(A_TAG, 32'h400);
    store(A_DATA, dw(7, 3, 4, 1, 1));
    for (int i = 0; i < 3; i++) begin
      u_if.pc = pcs[i];
      exp_q.push_back(exps[i]);
      cyc();
      got = obs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL stager_lookup pc=%h got=%h exp=%h", pcs[i], got, exp);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] pcs [8];
    logic [28:0] exps [8];
    store(A_CFG, 32'h3);
    for (int i = 0; i < 16; i++)
      add(32'h1000 + 32'(4 * i), dw(16'(16 + i), 5'(i), 0, 0, 1));
    add(32'h2000, dw(16'h55, 0, 0, 0, 1));
    add(32'h1004, dw(9, 1, 0, 0, 1));
    u_if.pc = 32'h1004;
    exp_q.push_back(hv(9, 1, 0, 0));
    cyc();
    got = obs();
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rewrite_in_place got=%h exp=%h", got, exp);
    end
    add(32'h3000, dw(16'h77, 2, 3, 1, 1));
    pcs[0] = 32'h400;  exps[0] = 29'd0;
    pcs[1] = 32'h1000; exps[1] = 29'd0;
    pcs[2] = 32'h2000; exps[2] = hv(16'h55, 0, 0, 0);
    pcs[3] = 32'h1038; exps[3] = hv(30, 14, 0, 0);
    pcs[4] = 32'h103C; exps[4] = hv(31, 15, 0, 0);
    pcs[5] = 32'h1004; exps[5] = 29'd0;
    pcs[6] = 32'h1008; exps[6] = hv(18, 2, 0, 0);
    pcs[7] = 32'h3000; exps[7] = hv(16'h77, 2, 3, 1);
    for (int i = 0; i < 8; i++) begin
      u_if.pc = pcs[i];
      exp_q.push_back(exps[i]);
      cyc();
      got = obs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL fill_lookup pc=%h got=%h exp=%h", pcs[i], got, exp);
      end
    end
  endtask

  task automatic test_invalidate();
    logic [31:0] pcs [6];
    logic [28:0] exps [6];
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: add(32'h200, dw(3, 1, 2, 0, 1));
        1: add(32'h200, dw(0, 0, 0, 0, 0));
        2: ;
        3: store(A_CFG, 32'h3);
        4: begin
          store(A_CFG, 32'h0);
          n_cmp++;
          if (u_if.sasa_enable !== 1'b0) begin
            n_err++;
            $display("FAIL enable_clear got=%b exp=0", u_if.sasa_enable);
          end
          add(32'h200, dw(3, 1, 2, 0, 1));
        end
        default: store(A_CFG, 32'h1);
      endcase
      case (i)
        0: begin pcs[i] = 32'h200;  exps[i] = hv(3, 1, 2, 0); end
        1: begin pcs[i] = 32'h200;  exps[i] = 29'd0; end
        2: begin pcs[i] = 32'h3000; exps[i] = hv(16'h77, 2, 3, 1); end
        3: begin pcs[i] = 32'h3000; exps[i] = 29'd0; end
        4: begin pcs[i] = 32'h200;  exps[i] = 29'd0; end
        default: begin pcs[i] = 32'h200; exps[i] = hv(3, 1, 2, 0); end
      endcase
      u_if.pc = pcs[i];
      exp_q.push_back(exps[i]);
      cyc();
      got = obs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL invalidate_step%0d pc=%h got=%h exp=%h", i, pcs[i], got, exp);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [28:0] exps [3];
    exps[0] = hv(3, 1, 2, 0);
    exps[1] = hv(3, 1, 2, 0);
    exps[2] = hv(10, 4, 5, 3);
    u_if.pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      u_if.sasa_wen  = (i < 2);
      u_if.sasa_addr = (i == 0) ? A_TAG : A_DATA;
      u_if.sasa_data = (i == 0) ? 32'h200 : dw(10, 4, 5, 3, 1);
      exp_q.push_back(exps[i]);
      cyc();
      got = obs();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL same_cycle_step%0d got=%h exp=%h", i, got, exp);
      end
    end
    u_if.sasa_wen = 1'b0;
  endtask

  task automatic test_reset_mid();
    store(A_TAG, 32'h500);
    nRST = 1'b0;
    #3;
    n_cmp++;
    if ({obs(), u_if.sasa_enable} !== 30'd0) begin
      n_err++;
      $display("FAIL async_reset got=%h exp=0", {obs(), u_if.sasa_enable});
    end
    nRST = 1'b1;
    cyc();
    store(A_CFG, 32'h1);
    store(A_DATA, dw(6, 1, 1, 2, 1));
    u_if.pc = 32'h500;
    exp_q.push_back(29'd0);
    cyc();
    got = obs();
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_mid_data got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_stager();
    test_fill();
    test_invalidate();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
